vc_d_arbiter: RTL

- Sits between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the interconnect device.
- Each cycle it selects at most one VC head word and pops it.
- It routes the word to D0 or D1 by a destination bit, and registers the push toward the destination FIFO.
- It honours the D FIFOs' almost-full pause flags, avoids head-of-line blocking, and keeps per-destination word counters for the bench and main controller.

---
 rtl/vc_d_arbiter_if.sv | 33 +++
 rtl/vc_d_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/vc_d_arbiter_if.sv
// Bundle between the arbiter, the two VC FIFOs, the two destination FIFOs and the controller.
// The master modport is the arbiter side; slave is the surrounding FIFOs/controller.
interface vc_d_arbiter_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned CNT_W  = 8
);
    logic              enable;
    logic              vc0_empty;
    logic              vc1_empty;
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic              d0_pause;
    logic              d1_pause;
    logic              pop_vc0;
    logic              pop_vc1;
    logic              push_d0;
    logic              push_d1;
    logic [DATA_W-1:0] data_out;
    logic              grant_vc;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              idle;

    modport master (
        input  enable, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_pause, d1_pause,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out, grant_vc, cnt_d0, cnt_d1, idle
    );

    modport slave (
        output enable, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_pause, d1_pause,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out, grant_vc, cnt_d0, cnt_d1, idle
    );
endinterface

// File: rtl/vc_d_arbiter.sv
// Pops at most one VC head per cycle and forwards it to D0/D1 (chosen by DEST_BIT) through one
// register stage, with per-destination counters. Define ARB_RR_EN for round-robin tie-breaking.
module vc_d_arbiter #(
    parameter int unsigned DATA_W   = 6,
    parameter int unsigned DEST_BIT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic            clk,
    input logic            reset,
    vc_d_arbiter_if.master bus
);
    logic              pause0;
    logic              pause1;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              any_grant;
    logic [DATA_W-1:0] sel_word;

    // A head blocked by its own destination is skipped, letting the other VC through.
    always_comb begin
        pause0 = bus.vc0_data[DEST_BIT] ? bus.d1_pause : bus.d0_pause;
        pause1 = bus.vc1_data[DEST_BIT] ? bus.d1_pause : bus.d0_pause;
        elig0  = bus.enable & ~reset & ~bus.vc0_empty & ~pause0;
        elig1  = bus.enable & ~reset & ~bus.vc1_empty & ~pause1;
    end

`ifdef ARB_RR_EN
    logic last_grant;

    always_comb begin
        grant1 = elig1 & (~elig0 | ~last_grant);
        grant0 = elig0 & ~grant1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (any_grant) begin
            last_grant <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = elig0;
        grant1 = elig1 & ~elig0;
    end
`endif

    always_comb begin
        any_grant   = grant0 | grant1;
        sel_word    = grant1 ? bus.vc1_data : bus.vc0_data;
        bus.pop_vc0 = grant0;
        bus.pop_vc1 = grant1;
        bus.idle    = bus.vc0_empty & bus.vc1_empty & ~bus.push_d0 & ~bus.push_d1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.push_d0  <= 1'b0;
            bus.push_d1  <= 1'b0;
            bus.data_out <= '0;
            bus.grant_vc <= 1'b0;
            bus.cnt_d0   <= '0;
            bus.cnt_d1   <= '0;
        end else begin
            bus.push_d0 <= any_grant & ~sel_word[DEST_BIT];
            bus.push_d1 <= any_grant &  sel_word[DEST_BIT];
            // data_out/grant_vc keep the last forwarded word when nothing is granted
            if (any_grant) begin
                bus.data_out <= sel_word;
                bus.grant_vc <= grant1;
            end
            if (bus.push_d0) begin
                bus.cnt_d0 <= bus.cnt_d0 + CNT_W'(1);
            end
            if (bus.push_d1) begin
                bus.cnt_d1 <= bus.cnt_d1 + CNT_W'(1);
            end
        end
    end
endmodule
